// File: rtl/qr_bch_pkg.sv
// Shared constants, state encoding and the single-step remainder update for
// the QR format/version BCH encoder.
package qr_bch_pkg;

  localparam logic [10:0] FMT_GEN  = 11'h537;
  localparam logic [14:0] FMT_MASK = 15'h5412;
  localparam logic [12:0] VER_GEN  = 13'h1F25;

  localparam int unsigned K_FMT   = 5;
  localparam int unsigned K_VER   = 6;
  localparam int unsigned DEG_FMT = 10;
  localparam int unsigned DEG_VER = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One message bit into the division register; format keeps only 10 live bits.
  function automatic logic [11:0] bch_step(input logic [11:0] rem,
                                           input logic        d,
                                           input logic        ver);
    logic        fb;
    logic [11:0] nxt;
    if (ver) begin
      fb  = d ^ rem[11];
      nxt = {rem[10:0], 1'b0} ^ (fb ? VER_GEN[11:0] : 12'h000);
    end else begin
      fb  = d ^ rem[9];
      nxt = {2'b00, rem[8:0], 1'b0} ^ (fb ? {2'b00, FMT_GEN[9:0]} : 12'h000);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/qr_bch_lfsr.sv
// Bit-serial remainder register for the BCH(15,5) / BCH(18,6) division.
module qr_bch_lfsr
  import qr_bch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_i,
  input  logic        mode_i,
  output logic [11:0] rem_o
);

  logic [11:0] rem_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rem_q <= 12'h000;
    end else if (en_i) begin
      rem_q <= bch_step(rem_q, bit_i, mode_i);
    end
  end

  assign rem_o = rem_q;

endmodule

// File: rtl/qr_bch_enc_seq.sv
// Sequential systematic BCH encoder for QR format (15,5) and version (18,6)
// information, with valid/ready handshakes and one codeword in flight.
module qr_bch_enc_seq
  import qr_bch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [5:0]  data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] codeword_out,
  output logic        mode_out,
  output logic        busy
);

  state_e      state_q;
  logic        mode_q;
  logic [5:0]  data_q;
  logic [5:0]  shift_q;
  logic [2:0]  cnt_q;
  logic        out_valid_q;
  logic [17:0] codeword_q;
  logic        mode_out_q;
  logic [11:0] rem;
  logic [11:0] rem_final_d;
  logic [17:0] codeword_d;
  logic        accept;
  logic        shifting;

  assign accept   = (state_q == IDLE) && in_valid;
  assign shifting = (state_q == SHIFT);

  qr_bch_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (accept),
    .en_i    (shifting),
    .bit_i   (shift_q[5]),
    .mode_i  (mode_q),
    .rem_o   (rem)
  );

  // The codeword is captured on the same edge as the final division step,
  // so the remainder it uses includes that last step.
  always_comb begin
    rem_final_d = bch_step(rem, shift_q[5], mode_q);
    if (mode_q) begin
      codeword_d = {data_q, rem_final_d};
    end else begin
      codeword_d = {3'b000, {data_q[4:0], rem_final_d[9:0]} ^ FMT_MASK};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      data_q      <= 6'd0;
      shift_q     <= 6'd0;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      codeword_q  <= 18'd0;
      mode_out_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q  <= mode;
            // Format messages are left-aligned so the serial MSB is always bit 5.
            data_q  <= mode ? data_in : {1'b0, data_in[4:0]};
            shift_q <= mode ? data_in : {data_in[4:0], 1'b0};
            cnt_q   <= mode ? 3'(K_VER - 1) : 3'(K_FMT - 1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q <= {shift_q[4:0], 1'b0};
          cnt_q   <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            out_valid_q <= 1'b1;
            codeword_q  <= codeword_d;
            mode_out_q  <= mode_q;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_valid_q;
  assign codeword_out = codeword_q;
  assign mode_out     = mode_out_q;

endmodule

// File: tb/tb_qr_bch_enc_seq.sv
// Self-checking bench for qr_bch_enc_seq against a long-division reference
// model of the QR format and version BCH codes.
module tb_qr_bch_enc_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [5:0]  data_in;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] codeword_out;
  logic        mode_out;
  logic        busy;

  int compared;
  int mismatched;
  longint cycleCount;

  qr_bch_enc_seq dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode         (mode),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .codeword_out (codeword_out),
    .mode_out     (mode_out),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Systematic encoding by polynomial long division of msg * x^deg.
  function automatic logic [17:0] refCodeword(input logic m, input logic [5:0] d);
    int unsigned msg, k, deg, gen, v, cw;
    if (m) begin
      msg = 32'(d); k = 6; deg = 12; gen = 32'h1F25;
    end else begin
      msg = 32'(d[4:0]); k = 5; deg = 10; gen = 32'h537;
    end
    v = msg << deg;
    for (int i = int'(deg + k) - 1; i >= int'(deg); i--) begin
      if (v[i]) v = v ^ (gen << (i - int'(deg)));
    end
    cw = (msg << deg) | v;
    if (!m) cw = cw ^ 32'h5412;
    return cw[17:0];
  endfunction

  // Drives one request, waits for its codeword, then stalls the handshake.
  // lat counts edges after acceptance until out_valid is first seen high;
  // the downstream sampling edge is the one after that.
  task automatic applyStimulus(input logic m, input logic [5:0] d, input int stall,
                               output logic [17:0] cw, output logic mo,
                               output int lat, output longint acceptCyc,
                               output bit timedOut);
    int guard;
    timedOut = 1'b0;
    mode     = m;
    data_in  = d;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) timedOut = 1'b1;
    @(posedge clk); #1;
    acceptCyc = cycleCount;
    in_valid  = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) timedOut = 1'b1;
    cw = codeword_out;
    mo = mode_out;
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        codeword_out !== 18'd0 || mode_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b cw=%h mode_out=%b, required 1 0 0 00000 0",
               in_ready, out_valid, busy, codeword_out, mode_out);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_format();
    logic [5:0]  vecs [3];
    logic [17:0] want [3];
    logic [17:0] cw;
    logic        mo;
    int          lat;
    longint      ac;
    bit          to;
    vecs[0] = 6'b000000; want[0] = 18'h05412;
    vecs[1] = 6'b000001; want[1] = 18'h05125;
    vecs[2] = 6'b100001; want[2] = 18'h05125;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, vecs[i], 0, cw, mo, lat, ac, to);
      compared++;
      if (to || cw !== want[i] || mo !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL format_%0d: cw=%h mode_out=%b timeout=%0d, required %h 0 0",
                 i, cw, mo, to, want[i]);
      end
      compared++;
      if (lat + 1 !== 6) begin
        mismatched++;
        $display("[TB] FAIL format_latency_%0d: %0d cycles, required 6", i, lat + 1);
      end
    end
  endtask

  task automatic test_version();
    logic [5:0]  vecs [2];
    logic [17:0] want [2];
    logic [17:0] cw;
    logic        mo;
    int          lat;
    longint      ac;
    bit          to;
    vecs[0] = 6'd7; want[0] = 18'h07C94;
    vecs[1] = 6'd0; want[1] = 18'h00000;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, vecs[i], 0, cw, mo, lat, ac, to);
      compared++;
      if (to || cw !== want[i] || mo !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL version_%0d: cw=%h mode_out=%b timeout=%0d, required %h 1 0",
                 i, cw, mo, to, want[i]);
      end
      compared++;
      if (lat + 1 !== 7) begin
        mismatched++;
        $display("[TB] FAIL version_latency_%0d: %0d cycles, required 7", i, lat + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    mode     = 1'b1;
    data_in  = 6'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    mode     = 1'b0;
    data_in  = 6'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      compared++;
      if (out_valid !== 1'b1 || codeword_out !== 18'h07C94 || in_ready !== 1'b0 ||
          mode_out !== 1'b1 || busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL stall_hold_%0d: out_valid=%b cw=%h in_ready=%b mode_out=%b busy=%b, required 1 07c94 0 1 1",
                 i, out_valid, codeword_out, in_ready, mode_out, busy);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    compared++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_second_accept: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    compared++;
    if (out_valid !== 1'b1 || codeword_out !== 18'h05125 || mode_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_second_word: out_valid=%b cw=%h mode_out=%b, required 1 05125 0",
               out_valid, codeword_out, mode_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    logic [17:0] cw;
    logic        mo;
    int          lat;
    longint      ac;
    bit          to;
    bit          sawValid;
    mode     = 1'b0;
    data_in  = 6'h1F;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_state: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               out_valid, in_ready, busy);
    end
    sawValid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    compared++;
    if (sawValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_no_output: out_valid seen=%b, required 0", sawValid);
    end
    applyStimulus(1'b0, 6'd0, 0, cw, mo, lat, ac, to);
    compared++;
    if (to || cw !== 18'h05412) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_followup: cw=%h timeout=%0d, required 05412 0", cw, to);
    end
  endtask

  task automatic test_random();
    logic [17:0] cw;
    logic        mo;
    logic        m;
    logic [5:0]  d;
    int          lat;
    longint      ac;
    bit          to;
    for (int i = 0; i < 20; i++) begin
      m = 1'($urandom_range(0, 1));
      d = 6'($urandom_range(0, 63));
      applyStimulus(m, d, int'($urandom_range(0, 3)), cw, mo, lat, ac, to);
      compared++;
      if (to || cw !== refCodeword(m, d) || mo !== m || lat !== (m ? 6 : 5)) begin
        mismatched++;
        $display("[TB] FAIL random_%0d: mode=%b data=%h cw=%h mode_out=%b lat=%0d, required %h %b %0d",
                 i, m, d, cw, mo, lat, refCodeword(m, d), m, m ? 6 : 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] cw;
    logic        mo;
    logic        m;
    logic        prevM;
    logic [5:0]  d;
    int          lat;
    int          fmtLeft;
    int          verLeft;
    longint      ac;
    longint      prevAc;
    bit          to;
    bit          first;
    fmtLeft = 32;
    verLeft = 64;
    first   = 1'b1;
    prevM   = 1'b0;
    prevAc  = 0;
    out_ready = 1'b1;
    while (fmtLeft + verLeft > 0) begin
      if (fmtLeft == 0) m = 1'b1;
      else if (verLeft == 0) m = 1'b0;
      else m = ($urandom_range(0, fmtLeft + verLeft - 1) >= fmtLeft) ? 1'b1 : 1'b0;
      if (m) verLeft--; else fmtLeft--;
      d = 6'($urandom_range(0, 63));
      applyStimulus(m, d, 0, cw, mo, lat, ac, to);
      compared++;
      if (to || cw !== refCodeword(m, d) || mo !== m) begin
        mismatched++;
        $display("[TB] FAIL b2b_word: mode=%b data=%h cw=%h mode_out=%b, required %h %b",
                 m, d, cw, mo, refCodeword(m, d), m);
      end
      if (!first) begin
        compared++;
        if (ac - prevAc !== (prevM ? 64'd8 : 64'd7)) begin
          mismatched++;
          $display("[TB] FAIL b2b_spacing: %0d cycles, required %0d",
                   ac - prevAc, prevM ? 8 : 7);
        end
      end
      first  = 1'b0;
      prevAc = ac;
      prevM  = m;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cycleCount = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    mode       = 1'b0;
    data_in    = 6'd0;
    out_ready  = 1'b1;
    test_reset();
    test_format();
    test_version();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
